// File: rtl/rca_sum_7seg_scan_pkg.sv
// Shared definitions for the adder-result display stage: FSM states,
// active-high 7-segment codes {g,f,e,d,c,b,a} and the double-dabble nibble fix-up.
package rca_sum_7seg_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Shift-add-3 correction applied to a BCD nibble before each left shift.
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/rca_sum_7seg_scan_bcd_to_7seg.sv
// Combinational BCD digit to 7-segment decoder; non-decimal nibbles blank the digit.
module bcd_to_7seg
    import rca_sum_7seg_scan_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Map one BCD digit to its segment pattern.
    always_comb begin
        seg_o = SEG_BLANK;
        unique case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/rca_sum_7seg_scan.sv
// Display stage for the ripple-carry adder: captures {cout,sum} on i_valid,
// converts it to BCD with a sequential double-dabble engine, and scans the
// committed digits onto a multiplexed 7-segment display.
// Optional build macro LEAD_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module rca_sum_7seg_scan
    import rca_sum_7seg_scan_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_valid,
    input  logic [WIDTH-1:0]    i_sum,
    input  logic                i_cout,
    output logic                o_busy,
    output logic                o_done,
    output logic [4*DIGITS-1:0] o_bcd,
    output logic [6:0]          o_seg,
    output logic [DIGITS-1:0]   o_an
);

    localparam int VAL_W   = WIDTH + 1;
    localparam int BCD_W   = 4 * DIGITS;
    localparam int ITER_W  = $clog2(VAL_W);
    localparam int PRESC_W = $clog2(SCAN_DIV);
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_e              state_q, state_d;
    logic [VAL_W-1:0]    shift_q, shift_d;
    logic [BCD_W-1:0]    work_q,  work_d;
    logic [ITER_W-1:0]   iter_q,  iter_d;
    logic [BCD_W-1:0]    disp_q,  disp_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [IDX_W-1:0]    idx_q,   idx_d;
    logic [DIGITS-1:0]   an_q,    an_d;
    logic [6:0]          seg_q,   seg_d;

    logic [BCD_W-1:0]    work_adj;
    logic [3:0]          sel_nibble;
    logic [6:0]          sel_seg;
    logic                sel_blank;

    // Conversion FSM and double-dabble datapath next-state.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned, which would infer a latch.
        state_d  = state_q;
        shift_d  = shift_q;
        work_d   = work_q;
        iter_d   = iter_q;
        disp_d   = disp_q;
        work_adj = work_q;
        for (int d = 0; d < DIGITS; d++) begin
            work_adj[4*d +: 4] = add3(work_q[4*d +: 4]);
        end
        unique case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    shift_d = {i_cout, i_sum};
                    work_d  = '0;
                    iter_d  = '0;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                {work_d, shift_d} = {work_adj, shift_q} << 1;
                iter_d            = iter_q + ITER_W'(1);
                if (iter_q == ITER_W'(WIDTH)) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                disp_d  = work_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Conversion state registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= ST_IDLE;
            shift_q <= '0;
            work_q  <= '0;
            iter_q  <= '0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            work_q  <= work_d;
            iter_q  <= iter_d;
            disp_q  <= disp_d;
        end
    end

    // Pick the digit under the scan index and decide whether it is a leading zero.
    always_comb begin
        sel_nibble = disp_q[3:0];
        sel_blank  = (idx_q != '0);
        for (int d = 0; d < DIGITS; d++) begin
            if (idx_q == IDX_W'(d)) begin
                sel_nibble = disp_q[4*d +: 4];
            end
            if (d >= int'(idx_q) && disp_q[4*d +: 4] != 4'd0) begin
                sel_blank = 1'b0;
            end
        end
    end

    bcd_to_7seg u_dec (
        .bcd_i (sel_nibble),
        .seg_o (sel_seg)
    );

    // Free-running prescaler, digit index and registered anode/segment drive.
    always_comb begin
        presc_d = presc_q + PRESC_W'(1);
        idx_d   = idx_q;
        if (presc_q == PRESC_W'(SCAN_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        an_d = DIGITS'(1) << idx_q;
`ifdef LEAD_ZERO_BLANK_EN
        seg_d = sel_blank ? SEG_BLANK : sel_seg;
`else
        seg_d = sel_seg;
`endif
    end

    // Scan registers; display starts on the ones digit showing "0".
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            an_q    <= DIGITS'(1);
            seg_q   <= SEG_0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign o_busy = (state_q != ST_IDLE);
    assign o_done = (state_q == ST_COMMIT);
    assign o_bcd  = disp_q;
    assign o_an   = an_q;
    assign o_seg  = seg_q;

endmodule

// File: tb/tb_rca_sum_7seg_scan.sv
// Scoreboard bench for rca_sum_7seg_scan (WIDTH=8, DIGITS=3, SCAN_DIV=4).
// Stimulus pushes expected BCD; a monitor pops on o_done and compares committed o_bcd.
module tb_rca_sum_7seg_scan;

    localparam int WIDTH    = 8;
    localparam int DIGITS   = 3;
    localparam int SCAN_DIV = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              i_valid;
    logic [WIDTH-1:0]  i_sum;
    logic              i_cout;
    logic              o_busy;
    logic              o_done;
    logic [11:0]       o_bcd;
    logic [6:0]        o_seg;
    logic [2:0]        o_an;

    int checks   = 0;
    int failures = 0;
    logic [11:0] exp_q[$];

    rca_sum_7seg_scan #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .i_valid (i_valid),
        .i_sum   (i_sum),
        .i_cout  (i_cout),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_bcd   (o_bcd),
        .o_seg   (o_seg),
        .o_an    (o_an)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Expected segments for the digit selected by a one-hot anode value.
    function automatic logic [6:0] exp_seg(input logic [11:0] val, input logic [2:0] an);
        int idx;
        logic blank;
        idx = (an == 3'b001) ? 0 : (an == 3'b010) ? 1 : 2;
        blank = (idx != 0);
        for (int d = idx; d < DIGITS; d++) begin
            if (val[4*d +: 4] != 4'd0) blank = 1'b0;
        end
`ifdef LEAD_ZERO_BLANK_EN
        if (blank) return 7'h00;
`endif
        return seg_of(val[4*idx +: 4]);
    endfunction

    // Monitor: on every o_done, pop the expected value and compare o_bcd after the commit edge.
    initial begin
        logic [11:0] exp;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && o_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", o_done, 0);
                end else begin
                    exp = exp_q.pop_front();
                    @(posedge clk);
                    #1;
                    check("bcd_commit", o_bcd, exp);
                end
            end
        end
    end

    task automatic send(input logic [7:0] s, input logic c);
        @(negedge clk);
        i_sum   = s;
        i_cout  = c;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (o_done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", o_done, 1);
        @(negedge clk);
    endtask

    // Sample the scan outputs each cycle; check one-hot, rotation, hold length and optionally segments.
    task automatic scan_check(input int n, input bit segs, input logic [11:0] val);
        logic [2:0] prev;
        int run = 0;
        bit seen_change = 1'b0;
        @(posedge clk);
        #1;
        prev = o_an;
        run  = 1;
        for (int i = 1; i < n; i++) begin
            @(posedge clk);
            #1;
            check("an_onehot", $onehot(o_an), 1);
            if (segs) check("seg_value", o_seg, exp_seg(val, o_an));
            if (o_an !== prev) begin
                if (seen_change) check("an_hold", run, SCAN_DIV);
                check("an_next", o_an, {prev[1:0], prev[2]});
                seen_change = 1'b1;
                prev = o_an;
                run  = 1;
            end else begin
                run++;
                if (run > SCAN_DIV) check("an_stuck", run, SCAN_DIV);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        i_valid = 1'b0;
        i_sum   = '0;
        i_cout  = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_an",   o_an,   3'b001);
        check("rst_seg",  o_seg,  7'h3F);
        check("rst_bcd",  o_bcd,  12'h000);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 0x1FF = 511; latency and a dropped i_valid at N+3.
        exp_q.push_back(12'h511);
        send(8'hFF, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            check("busy_conv", o_busy, 1);
            check("done_timing", o_done, (k == 10));
            if (k == 3) begin
                i_sum   = 8'h01;
                i_cout  = 1'b0;
                i_valid = 1'b1;
            end
            if (k == 4) i_valid = 1'b0;
            @(negedge clk);
        end
        check("busy_after", o_busy, 0);
        check("done_after", o_done, 0);
        repeat (3) @(negedge clk);
        check("bcd_511_held", o_bcd, 12'h511);

        // Re-issue 1 after completion; scan rotation continues through the conversion.
        exp_q.push_back(12'h001);
        send(8'h01, 1'b0);
        scan_check(30, 1'b0, 12'h000);
        check("bcd_001", o_bcd, 12'h001);

        // 42 -> "042" (or " 42" with leading-zero blanking), checked on the scan.
        exp_q.push_back(12'h042);
        send(8'h2A, 1'b0);
        wait_done(40);
        repeat (3) @(negedge clk);
        scan_check(16, 1'b1, 12'h042);

        // Reset in the middle of a conversion.
        send(8'h63, 1'b0);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_busy", o_busy, 0);
        check("abort_done", o_done, 0);
        check("abort_bcd",  o_bcd,  12'h000);
        check("abort_an",   o_an,   3'b001);
        check("abort_seg",  o_seg,  7'h3F);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_bcd_kept", o_bcd, 12'h000);

        // Normal conversion after the abort: 99 -> "099".
        exp_q.push_back(12'h099);
        send(8'h63, 1'b0);
        wait_done(40);
        repeat (3) @(negedge clk);
        scan_check(16, 1'b1, 12'h099);

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
